// File: rtl/dstack_ctl_pkg.sv
// Shared opcode, stack-effect and error encodings for the data-stack controller.
// op_req() gives each opcode's minimum depth, depth growth and cycle count.
package dstack_ctl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LIT   = 4'h1,
        OP_DUP   = 4'h2,
        OP_DROP  = 4'h3,
        OP_SWAP  = 4'h4,
        OP_OVER  = 4'h5,
        OP_ADD   = 4'h6,
        OP_SUB   = 4'h7,
        OP_AND   = 4'h8,
        OP_OR    = 4'h9,
        OP_XOR   = 4'hA,
        OP_INC   = 4'hB,
        OP_INV   = 4'hC,
        OP_2DUP  = 4'hD,
        OP_2DROP = 4'hE,
        OP_ILL   = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        SE_NONE = 3'b000,
        SE_POP  = 3'b001,
        SE_PUSH = 3'b010,
        SE_RPLC = 3'b011,
        SE_SWAP = 3'b100
    } se_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNDER   = 2'd1,
        ERR_OVER    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_e;

    typedef struct packed {
        logic [1:0] min_depth;
        logic [1:0] grow;
        logic       two_cycle;
    } op_req_t;

    // grow is the peak depth increase, so overflow is simply depth+grow > DEPTH
    function automatic op_req_t op_req(input op_e op);
        op_req_t r;
        r = '0;
        case (op)
            OP_LIT:                          r.grow = 2'd1;
            OP_DUP:                          begin r.min_depth = 2'd1; r.grow = 2'd1; end
            OP_DROP, OP_INC, OP_INV:         r.min_depth = 2'd1;
            OP_SWAP:                         r.min_depth = 2'd2;
            OP_OVER:                         begin r.min_depth = 2'd2; r.grow = 2'd1; end
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_2DROP:                begin r.min_depth = 2'd2; r.two_cycle = 1'b1; end
            OP_2DUP:                         begin r.min_depth = 2'd2; r.grow = 2'd2; r.two_cycle = 1'b1; end
            default:                         r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dstack_alu.sv
// Combinational ALU for the stack controller: a = s1, b = s0, modulo 2^WIDTH.
module dstack_alu
    import dstack_ctl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_INC:  result = b + 1'b1;
            OP_INV:  result = ~b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dstack_ctl.sv
// Data-stack controller: turns opcodes into lifo_se stack effects, tracks depth,
// refuses underflow/overflow/illegal ops and latches the first error code.
module dstack_ctl
    import dstack_ctl_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 12,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [WIDTH-1:0] i_s0,
    input  logic [WIDTH-1:0] i_s1,
    output logic [2:0]       o_se,
    output logic [WIDTH-1:0] o_data,
    output logic [DW-1:0]    o_depth,
    output logic [1:0]       o_err
);

    state_e           state, state_nxt;
    op_e              r_op;
    logic [WIDTH-1:0] r_res;
    logic [DW-1:0]    r_depth, depth_nxt;
    err_e             r_err, err_nxt;

    op_e              op;
    op_req_t          req;
    logic [WIDTH-1:0] alu_y;
    logic             under, over, op_ld, res_ld;
    se_e              se;
    logic [WIDTH-1:0] data;

    assign op  = op_e'(i_op);
    assign req = op_req(op);

    dstack_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (i_op),
        .a      (i_s1),
        .b      (i_s0),
        .result (alu_y)
    );

    always_comb begin
        state_nxt = state;
        depth_nxt = r_depth;
        err_nxt   = r_err;
        se        = SE_NONE;
        data      = '0;
        op_ld     = 1'b0;
        res_ld    = 1'b0;
        under     = r_depth < DW'(req.min_depth);
        over      = ({1'b0, r_depth} + (DW+1)'(req.grow)) > (DW+1)'(DEPTH);

        if (state == ST_IDLE) begin
            if (i_valid) begin
                if (op == OP_ILL || under || over) begin
                    if (r_err == ERR_NONE)
                        err_nxt = (op == OP_ILL) ? ERR_ILLEGAL :
                                  under          ? ERR_UNDER   : ERR_OVER;
                end else begin
                    state_nxt = req.two_cycle ? ST_SECOND : ST_IDLE;
                    op_ld     = req.two_cycle;
                    case (op)
                        OP_LIT:  begin se = SE_PUSH; data = i_imm; depth_nxt = r_depth + 1'b1; end
                        OP_DUP:  begin se = SE_PUSH; data = i_s0;  depth_nxt = r_depth + 1'b1; end
                        OP_DROP: begin se = SE_POP;                depth_nxt = r_depth - 1'b1; end
                        OP_SWAP: se = SE_SWAP;
                        OP_OVER: begin se = SE_PUSH; data = i_s1;  depth_nxt = r_depth + 1'b1; end
                        OP_INC, OP_INV: begin se = SE_RPLC; data = alu_y; end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            se        = SE_POP;
                            res_ld    = 1'b1;
                            depth_nxt = r_depth - 1'b1;
                        end
                        OP_2DUP:  begin se = SE_PUSH; data = i_s1; depth_nxt = r_depth + 1'b1; end
                        OP_2DROP: begin se = SE_POP;               depth_nxt = r_depth - 1'b1; end
                        default:  se = SE_NONE;
                    endcase
                end
            end
        end else begin
            state_nxt = ST_IDLE;
            // i_s1 here already reflects the first push, i.e. the original s0
            case (r_op)
                OP_2DUP:  begin se = SE_PUSH; data = i_s1; depth_nxt = r_depth + 1'b1; end
                OP_2DROP: begin se = SE_POP;               depth_nxt = r_depth - 1'b1; end
                default:  begin se = SE_RPLC; data = r_res; end
            endcase
        end

        if (i_rst)
            se = SE_NONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            r_op    <= OP_NOP;
            r_res   <= '0;
            r_depth <= '0;
            r_err   <= ERR_NONE;
        end else begin
            state   <= state_nxt;
            r_depth <= depth_nxt;
            r_err   <= err_nxt;
            if (op_ld)
                r_op <= op;
            if (res_ld)
                r_res <= alu_y;
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_se    = se;
    assign o_data  = data;
    assign o_depth = r_depth;
    assign o_err   = r_err;

endmodule
